// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer (99..00) with a one-second prescaler and
// start/pause/load controls; digits feed seven-segment decoders directly.
module bcd_countdown #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       done
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic          zero_s;
  logic          step_s;
  logic          wrap_s;
  logic          tick_s;
  logic          last_s;
  logic [3:0]    dec_tens_s;
  logic [3:0]    dec_units_s;

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Next-state, prescaler and digit update logic.
  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    units_d     = units_q;
    presc_d     = presc_q;
    step_s      = 1'b0;
    zero_s      = (tens_q == 4'd0) && (units_q == 4'd0);
    last_s      = (tens_q == 4'd0) && (units_q == 4'd1);
    dec_units_s = (units_q != 4'd0) ? (units_q - 4'd1) : 4'd9;
    dec_tens_s  = (units_q != 4'd0) ? tens_q : (tens_q - 4'd1);

    if (load && (state_q != RUN)) begin
      tens_d  = sat_digit(load_tens);
      units_d = sat_digit(load_units);
      presc_d = '0;
      state_d = (state_q == PAUSED) ? PAUSED : IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSED: begin
          if (start && zero_s) begin
            state_d = DONE;
          end else if (start) begin
            state_d = RUN;
            // The resume cycle counts as a running cycle so the held phase is preserved.
            step_s  = (state_q == PAUSED);
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          step_s  = 1'b1;
          state_d = pause ? PAUSED : RUN;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    wrap_s  = (presc_q == PRESC_MAX);
    tick_s  = step_s && wrap_s;
    presc_d = step_s ? (wrap_s ? '0 : (presc_q + PW'(1))) : presc_d;
    tens_d  = tick_s ? dec_tens_s  : tens_d;
    units_d = tick_s ? dec_units_s : units_d;
    // Reaching 00 overrides a coincident pause.
    state_d = (tick_s && last_s) ? DONE : state_d;

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, digit, prescaler and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign tens    = tens_q;
  assign units   = units_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: decimal-count reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_countdown;

  localparam int TPS = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  typedef struct {
    int count;
    int mode;
    int elapsed;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_units = 4'd0;
  logic [3:0] tens;
  logic [3:0] units;
  logic       running;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;
  mstate_t m = '{0, M_IDLE, 0};

  bcd_countdown #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .load(load),
    .load_tens(load_tens), .load_units(load_units),
    .tens(tens), .units(units), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  // One running cycle: count elapsed cycles, every TPS of them takes a second off.
  function automatic mstate_t advance(input mstate_t s);
    mstate_t n = s;
    n.elapsed = s.elapsed + 1;
    if (n.elapsed == TPS) begin
      n.elapsed = 0;
      n.count = s.count - 1;
      if (n.count == 0) n.mode = M_DONE;
    end
    return n;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic st, input logic pa,
                                         input logic ld, input int lt, input int lu);
    mstate_t n = s;
    if (ld && s.mode != M_RUN) begin
      n.count = ((lt > 9) ? 9 : lt) * 10 + ((lu > 9) ? 9 : lu);
      n.elapsed = 0;
      n.mode = (s.mode == M_PAUSED) ? M_PAUSED : M_IDLE;
    end else if (st && (s.mode == M_IDLE || s.mode == M_PAUSED)) begin
      if (s.count == 0) n.mode = M_DONE;
      else begin
        n.mode = M_RUN;
        if (s.mode == M_PAUSED) n = advance(n);
      end
    end else if (s.mode == M_RUN) begin
      if (pa) n.mode = M_PAUSED;
      n = advance(n);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, M_IDLE, 0};
    else m <= model_next(m, start, pause, load, int'(load_tens), int'(load_units));
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_tens", int'(tens), m.count / 10);
    check("model_units", int'(units), m.count % 10);
    check("model_running", int'(running), (m.mode == M_RUN) ? 1 : 0);
    check("model_done", int'(done), (m.mode == M_DONE) ? 1 : 0);
  end

  task automatic check_out(input string name, input int t, input int u, input int r, input int d);
    check({name, "_tens"}, int'(tens), t);
    check({name, "_units"}, int'(units), u);
    check({name, "_running"}, int'(running), r);
    check({name, "_done"}, int'(done), d);
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] u);
    load_tens = t;
    load_units = u;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_out("reset", 0, 0, 0, 0);

    // Basic countdown with borrow from 12.
    do_load(4'd1, 4'd2);
    check_out("load_12", 1, 2, 0, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    check_out("pre_tick", 1, 2, 1, 0);
    @(negedge clk);
    check_out("tick_4", 1, 1, 1, 0);
    repeat (4) @(negedge clk);
    check_out("tick_8", 1, 0, 1, 0);
    repeat (4) @(negedge clk);
    check_out("borrow_12", 0, 9, 1, 0);
    repeat (35) @(negedge clk);
    check_out("last_01", 0, 1, 1, 0);
    @(negedge clk);
    check_out("expire_48", 0, 0, 0, 1);
    pulse_start();
    check_out("start_in_done", 0, 0, 0, 1);

    // Saturation and load ignored while running.
    do_load(4'hA, 4'hF);
    check_out("saturate", 9, 9, 0, 0);
    pulse_start();
    @(negedge clk);
    do_load(4'd3, 4'd3);
    check_out("load_in_run", 9, 9, 1, 0);
    do_reset();

    // Pause and resume with held prescaler = 2.
    do_load(4'd0, 4'd5);
    pulse_start();
    @(negedge clk);
    pulse_pause();
    check_out("paused", 0, 5, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_out("pause_hold", 0, 5, 0, 0);
    end
    pulse_start();
    check_out("resume", 0, 5, 1, 0);
    @(negedge clk);
    check_out("resume_tick", 0, 4, 1, 0);
    do_reset();

    // Start at zero, then load out of DONE, then load beats start.
    pulse_start();
    check_out("start_zero", 0, 0, 0, 1);
    do_load(4'd0, 4'd3);
    check_out("load_from_done", 0, 3, 0, 0);
    load_tens = 4'd2;
    load_units = 4'd2;
    load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    check_out("load_beats_start", 2, 2, 0, 0);

    // Pause on the same cycle as the final tick.
    do_load(4'd0, 4'd1);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_pause();
    check_out("pause_final_tick", 0, 0, 0, 1);

    // Asynchronous reset while counting from 37.
    do_load(4'd3, 4'd7);
    pulse_start();
    repeat (6) @(negedge clk);
    check_out("run_36", 3, 6, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_out("after_reset", 0, 0, 0, 0);
    pulse_start();
    check_out("start_after_reset", 0, 0, 0, 1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
